tlk2711_axil_reg_bridge: RTL and testbench

AXI4-Lite slave that turns PS register accesses into the single-cycle register bus (reg_wen/waddr/wdata, reg_ren/raddr/rdata) consumed by the TLK2711 register manager. It sits between the PS AXI-Lite master port and the reg_mgt register bus, in the ps_clk domain. The write and read channels are independent FSMs, so one write and one read can be in flight concurrently. Out-of-range or partial-strobe accesses are rejected with SLVERR and never reach the register bus.

---
 rtl/tlk2711_axil_reg_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_tlk2711_axil_reg_bridge.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_axil_reg_bridge.sv
// AXI4-Lite slave bridging PS register accesses onto the single-cycle TLK2711 reg_mgt bus.
// Optional SLVERR counter output o_err_cnt when TLK_AXIL_ERR_CNT_EN is defined.
module tlk2711_axil_reg_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 16,
  parameter int REG_NUM        = 256,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      ps_clk,
  input  logic                      ps_rst,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic                      o_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] o_reg_waddr,
  output logic [DATA_WIDTH-1:0]     o_reg_wdata,
  output logic                      o_reg_ren,
  output logic [REG_ADDR_WIDTH-1:0] o_reg_raddr,
  input  logic [DATA_WIDTH-1:0]     i_reg_rdata
`ifdef TLK_AXIL_ERR_CNT_EN
  ,
  output logic [15:0]               o_err_cnt
`endif
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] LAT_LAST    = (RD_LATENCY > 0) ? 3'(RD_LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {W_IDLE, W_STRB, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_STRB, R_WAIT, R_RESP} r_state_t;

  // Handshake contract on every AXI channel: a beat transfers on the rising edge
  // where valid and ready are both high; valid never drops before that edge.

  function automatic logic [REG_ADDR_WIDTH-1:0] word_index(input logic [AXI_ADDR_WIDTH-1:0] a);
    return REG_ADDR_WIDTH'(a >> LANE_BITS);
  endfunction

  function automatic logic index_ok(input logic [REG_ADDR_WIDTH-1:0] idx);
    return 64'(idx) < 64'(REG_NUM);
  endfunction

  // ---------------- write channel ----------------
  w_state_t                  w_state, w_state_nxt;
  logic                      aw_held, w_held, aw_held_nxt, w_held_nxt;
  logic                      awready_q, wready_q;
  logic [REG_ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic [1:0]                bresp_q;
  logic                      aw_hs, w_hs, wr_ok;

  assign aw_hs = s_axil_awvalid && awready_q;
  assign w_hs  = s_axil_wvalid && wready_q;
  assign wr_ok = index_ok(waddr_q) && (&wstrb_q);

  always_ff @(posedge ps_clk) begin
    if (ps_rst) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state   <= w_state_nxt;
      aw_held   <= aw_held_nxt;
      w_held    <= w_held_nxt;
      awready_q <= (w_state_nxt == W_IDLE) && !aw_held_nxt;
      wready_q  <= (w_state_nxt == W_IDLE) && !w_held_nxt;
      if (aw_hs) waddr_q <= word_index(s_axil_awaddr);
      if (w_hs) begin
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      if (w_state == W_STRB) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    aw_held_nxt = aw_held | aw_hs;
    w_held_nxt  = w_held | w_hs;
    case (w_state)
      W_IDLE: if (aw_held_nxt && w_held_nxt) w_state_nxt = W_STRB;
      W_STRB: w_state_nxt = W_RESP;
      W_RESP: begin
        if (s_axil_bready) begin
          w_state_nxt = W_IDLE;
          aw_held_nxt = 1'b0;
          w_held_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    o_reg_wen     = 1'b0;
    s_axil_bvalid = 1'b0;
    case (w_state)
      W_STRB:  o_reg_wen = wr_ok;
      W_RESP:  s_axil_bvalid = 1'b1;
      default: ;
    endcase
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bresp   = bresp_q;
  assign o_reg_waddr    = waddr_q;
  assign o_reg_wdata    = wdata_q;

  // ---------------- read channel ----------------
  r_state_t                  r_state, r_state_nxt;
  logic                      arready_q, rd_ok_q, ar_hs, rd_capture;
  logic [REG_ADDR_WIDTH-1:0] raddr_q;
  logic [2:0]                lat_cnt;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [1:0]                rresp_q;

  assign ar_hs = s_axil_arvalid && arready_q;
  // Read data is sampled on the last cycle of the latency window.
  assign rd_capture = ((r_state == R_STRB) && (RD_LATENCY == 0)) ||
                      ((r_state == R_WAIT) && (lat_cnt == LAT_LAST));

  always_ff @(posedge ps_clk) begin
    if (ps_rst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rd_ok_q   <= 1'b0;
      raddr_q   <= '0;
      lat_cnt   <= 3'd0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state   <= r_state_nxt;
      arready_q <= (r_state_nxt == R_IDLE);
      if (ar_hs) begin
        raddr_q <= word_index(s_axil_araddr);
        rd_ok_q <= index_ok(word_index(s_axil_araddr));
      end
      lat_cnt <= (r_state == R_WAIT) ? lat_cnt + 3'd1 : 3'd0;
      if (rd_capture) begin
        rdata_q <= rd_ok_q ? i_reg_rdata : '0;
        rresp_q <= rd_ok_q ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_STRB;
      R_STRB:  r_state_nxt = (RD_LATENCY == 0) ? R_RESP : R_WAIT;
      R_WAIT:  if (lat_cnt == LAT_LAST) r_state_nxt = R_RESP;
      R_RESP:  if (s_axil_rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    o_reg_ren     = 1'b0;
    s_axil_rvalid = 1'b0;
    case (r_state)
      R_STRB:  o_reg_ren = rd_ok_q;
      R_RESP:  s_axil_rvalid = 1'b1;
      default: ;
    endcase
  end

  assign s_axil_arready = arready_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign o_reg_raddr    = raddr_q;

`ifdef TLK_AXIL_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  always_comb begin
    err_inc = {1'b0, s_axil_bvalid && s_axil_bready && (bresp_q == RESP_SLVERR)} +
              {1'b0, s_axil_rvalid && s_axil_rready && (rresp_q == RESP_SLVERR)};
    err_sum = {1'b0, err_cnt_q} + {15'b0, err_inc};
  end

  always_ff @(posedge ps_clk) begin
    if (ps_rst) err_cnt_q <= 16'd0;
    else        err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// Bench for tlk2711_axil_reg_bridge: directed scenarios plus randomized traffic checked
// against a register-array model; a register-manager stub answers the reg bus.
module tb_tlk2711_axil_reg_bridge;
  localparam int TMO = 200;

  logic        ps_clk = 1'b0;
  logic        ps_rst = 1'b1;
  logic [31:0] s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0, s_axil_awready;
  logic [63:0] s_axil_wdata = '0;
  logic [7:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0, s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid, s_axil_bready = 1'b0;
  logic [31:0] s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0, s_axil_arready;
  logic [63:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid, s_axil_rready = 1'b0;
  logic        o_reg_wen, o_reg_ren;
  logic [15:0] o_reg_waddr, o_reg_raddr;
  logic [63:0] o_reg_wdata, i_reg_rdata = '0;
`ifdef TLK_AXIL_ERR_CNT_EN
  logic [15:0] o_err_cnt;
`endif

  tlk2711_axil_reg_bridge dut (
    .ps_clk(ps_clk), .ps_rst(ps_rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
    .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata)
`ifdef TLK_AXIL_ERR_CNT_EN
    , .o_err_cnt(o_err_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 ps_clk = ~ps_clk;
  int cyc = 0;
  always @(posedge ps_clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // ---------------- model and expected queues ----------------
  logic [63:0] model_regs [256];
  logic [63:0] regs [256];
  logic [79:0] exp_w_q [$];
  logic [1:0]  exp_b_q [$];
  logic [15:0] exp_ren_q [$];
  logic [65:0] exp_r_q [$];

  function automatic logic [15:0] model_idx(input logic [31:0] a);
    return 16'((a / 8) % 65536);
  endfunction

  task automatic expect_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [15:0] idx = model_idx(a);
    bit ok = (idx < 256) && (s == 8'hFF);
    exp_b_q.push_back(ok ? 2'b00 : 2'b10);
    if (ok) begin
      exp_w_q.push_back({idx, d});
      model_regs[idx[7:0]] = d;
    end
  endtask

  task automatic expect_read(input logic [31:0] a);
    logic [15:0] idx = model_idx(a);
    if (idx < 256) begin
      exp_ren_q.push_back(idx);
      exp_r_q.push_back({2'b00, model_regs[idx[7:0]]});
    end else begin
      exp_r_q.push_back({2'b10, 64'd0});
    end
  endtask

  // ---------------- register manager stub (read latency 1) ----------------
  bit          rd_pend = 0;
  logic [63:0] rd_val;
  always @(negedge ps_clk) begin
    if (!ps_rst && o_reg_wen) regs[o_reg_waddr[7:0]] = o_reg_wdata;
    if (!ps_rst && o_reg_ren) begin
      rd_pend = 1;
      rd_val  = regs[o_reg_raddr[7:0]];
    end
  end
  always @(posedge ps_clk) begin
    #1;
    if (rd_pend) begin
      i_reg_rdata = rd_val;
      rd_pend = 0;
    end else begin
      i_reg_rdata = {$urandom, $urandom};
    end
  end

  // ---------------- per-cycle compare process ----------------
  int aw_hs_cyc, w_hs_cyc, ar_hs_cyc, wen_cyc, ren_cyc, b_first_cyc, r_first_cyc;
  int wen_cnt = 0, ren_cnt = 0, b_cnt = 0, r_cnt = 0;
  int err_model = 0;
  logic [15:0] last_waddr, last_raddr;
  logic [63:0] last_wdata, last_rdata, prev_rdata;
  logic [1:0]  last_bresp, last_rresp, prev_bresp, prev_rresp;
  bit prev_wen = 0, prev_ren = 0, prev_bv = 0, prev_rv = 0, prev_bhold = 0, prev_rhold = 0;

  always @(negedge ps_clk) begin
    logic [79:0] ew;
    logic [65:0] er;
    if (ps_rst) begin
      prev_wen = 0; prev_ren = 0; prev_bv = 0; prev_rv = 0;
      prev_bhold = 0; prev_rhold = 0; err_model = 0;
    end else begin
`ifdef TLK_AXIL_ERR_CNT_EN
      chk("err_cnt", 64'(o_err_cnt), 64'(err_model));
`endif
      if (s_axil_awvalid && s_axil_awready) aw_hs_cyc = cyc;
      if (s_axil_wvalid && s_axil_wready) w_hs_cyc = cyc;
      if (s_axil_arvalid && s_axil_arready) ar_hs_cyc = cyc;
      if (o_reg_wen) begin
        wen_cnt++; wen_cyc = cyc; last_waddr = o_reg_waddr; last_wdata = o_reg_wdata;
        chk("wen_one_cycle", 64'(prev_wen), 64'(0));
        chk("wen_pending", 64'(exp_w_q.size() > 0), 64'(1));
        if (exp_w_q.size() > 0) begin
          ew = exp_w_q.pop_front();
          chk("waddr", 64'(o_reg_waddr), 64'(ew[79:64]));
          chk("wdata", o_reg_wdata, ew[63:0]);
        end
      end
      if (o_reg_ren) begin
        ren_cnt++; ren_cyc = cyc; last_raddr = o_reg_raddr;
        chk("ren_one_cycle", 64'(prev_ren), 64'(0));
        chk("ren_pending", 64'(exp_ren_q.size() > 0), 64'(1));
        if (exp_ren_q.size() > 0) chk("raddr", 64'(o_reg_raddr), 64'(exp_ren_q.pop_front()));
      end
      if (s_axil_bvalid && !prev_bv) b_first_cyc = cyc;
      if (prev_bhold) begin
        chk("b_hold_valid", 64'(s_axil_bvalid), 64'(1));
        chk("b_hold_resp", 64'(s_axil_bresp), 64'(prev_bresp));
      end
      if (s_axil_bvalid && s_axil_bready) begin
        b_cnt++; last_bresp = s_axil_bresp;
        chk("b_pending", 64'(exp_b_q.size() > 0), 64'(1));
        if (exp_b_q.size() > 0) chk("bresp", 64'(s_axil_bresp), 64'(exp_b_q.pop_front()));
        if (s_axil_bresp == 2'b10) err_model = (err_model < 65535) ? err_model + 1 : 65535;
      end
      if (s_axil_rvalid && !prev_rv) r_first_cyc = cyc;
      if (prev_rhold) begin
        chk("r_hold_valid", 64'(s_axil_rvalid), 64'(1));
        chk("r_hold_data", s_axil_rdata, prev_rdata);
        chk("r_hold_resp", 64'(s_axil_rresp), 64'(prev_rresp));
      end
      if (s_axil_rvalid && s_axil_rready) begin
        r_cnt++; last_rdata = s_axil_rdata; last_rresp = s_axil_rresp;
        chk("r_pending", 64'(exp_r_q.size() > 0), 64'(1));
        if (exp_r_q.size() > 0) begin
          er = exp_r_q.pop_front();
          chk("rresp", 64'(s_axil_rresp), 64'(er[65:64]));
          chk("rdata", s_axil_rdata, er[63:0]);
        end
        if (s_axil_rresp == 2'b10) err_model = (err_model < 65535) ? err_model + 1 : 65535;
      end
      prev_wen = o_reg_wen; prev_ren = o_reg_ren;
      prev_bv = s_axil_bvalid; prev_rv = s_axil_rvalid;
      prev_bhold = s_axil_bvalid && !s_axil_bready; prev_bresp = s_axil_bresp;
      prev_rhold = s_axil_rvalid && !s_axil_rready; prev_rresp = s_axil_rresp;
      prev_rdata = s_axil_rdata;
    end
  end

  // ---------------- driver tasks (all return at posedge + 1) ----------------
  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    s_axil_awaddr = a; s_axil_awvalid = 1'b1;
    while (!s_axil_awready && n < TMO) begin @(posedge ps_clk); #1; n++; end
    chk("aw_accept_in_time", 64'(s_axil_awready), 64'(1));
    if (s_axil_awready) begin @(posedge ps_clk); #1; end
    s_axil_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
    while (!s_axil_wready && n < TMO) begin @(posedge ps_clk); #1; n++; end
    chk("w_accept_in_time", 64'(s_axil_wready), 64'(1));
    if (s_axil_wready) begin @(posedge ps_clk); #1; end
    s_axil_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    s_axil_araddr = a; s_axil_arvalid = 1'b1;
    while (!s_axil_arready && n < TMO) begin @(posedge ps_clk); #1; n++; end
    chk("ar_accept_in_time", 64'(s_axil_arready), 64'(1));
    if (s_axil_arready) begin @(posedge ps_clk); #1; end
    s_axil_arvalid = 1'b0;
  endtask

  task automatic recv_b(input int stall);
    int n = 0;
    while (!s_axil_bvalid && n < TMO) begin @(posedge ps_clk); #1; n++; end
    chk("b_arrives_in_time", 64'(s_axil_bvalid), 64'(1));
    if (s_axil_bvalid) begin
      repeat (stall) begin @(posedge ps_clk); #1; end
      s_axil_bready = 1'b1;
      @(posedge ps_clk); #1;
      s_axil_bready = 1'b0;
    end
  endtask

  task automatic recv_r(input int stall);
    int n = 0;
    while (!s_axil_rvalid && n < TMO) begin @(posedge ps_clk); #1; n++; end
    chk("r_arrives_in_time", 64'(s_axil_rvalid), 64'(1));
    if (s_axil_rvalid) begin
      repeat (stall) begin @(posedge ps_clk); #1; end
      s_axil_rready = 1'b1;
      @(posedge ps_clk); #1;
      s_axil_rready = 1'b0;
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int lead, input int stall);
    expect_write(a, d, s);
    if (lead == 0) begin
      fork
        send_aw(a);
        send_w(d, s);
      join
    end else if (lead > 0) begin
      send_w(d, s);
      repeat (lead) begin @(posedge ps_clk); #1; end
      send_aw(a);
    end else begin
      send_aw(a);
      repeat (-lead) begin @(posedge ps_clk); #1; end
      send_w(d, s);
    end
    recv_b(stall);
  endtask

  task automatic axi_read(input logic [31:0] a, input int stall);
    expect_read(a);
    send_ar(a);
    recv_r(stall);
  endtask

  task automatic do_reset(input int n);
    ps_rst = 1'b1;
    repeat (n) begin @(posedge ps_clk); #1; end
    chk("rst_ctrl_zero", 64'({s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp,
                              s_axil_arready, s_axil_rvalid, s_axil_rresp, o_reg_wen, o_reg_ren}), 64'(0));
    chk("rst_rdata_zero", s_axil_rdata, 64'(0));
    chk("rst_wdata_zero", o_reg_wdata, 64'(0));
    chk("rst_addr_zero", 64'({o_reg_waddr, o_reg_raddr}), 64'(0));
    ps_rst = 1'b0;
    chk("ready_low_at_release", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'(0));
    @(posedge ps_clk); #1;
    chk("ready_rise_after_release", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'(3'b111));
  endtask

  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 9);
    logic [31:0] idx = 32'($urandom_range(0, 255));
    case (k)
      7:       return (32'($urandom_range(256, 300)) << 3) | 32'($urandom_range(0, 7));
      8:       return $urandom;
      9:       return (idx << 3) | 32'h0008_0000;
      default: return (idx << 3) | 32'($urandom_range(0, 7));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int w0, b0, r0, n0;
    logic [31:0] wa, ra;
    for (int i = 0; i < 256; i++) begin
      regs[i] = {$urandom, $urandom};
      model_regs[i] = regs[i];
    end
    do_reset(3);

    // AW and W together
    axi_write(32'h18, 64'h1122334455667788, 8'hFF, 0, 0);
    chk("t1_aw_w_same_cycle", 64'(w_hs_cyc), 64'(aw_hs_cyc));
    chk("t1_wen_latency", 64'(wen_cyc - aw_hs_cyc), 64'(1));
    chk("t1_waddr", 64'(last_waddr), 64'(3));
    chk("t1_wdata", last_wdata, 64'h1122334455667788);
    chk("t1_bvalid_latency", 64'(b_first_cyc - aw_hs_cyc), 64'(2));
    chk("t1_bresp", 64'(last_bresp), 64'(0));

    // W three cycles ahead of AW
    w0 = wen_cnt; b0 = b_cnt;
    expect_write(32'h08, 64'hA5A5_0000_1234_5678, 8'hFF);
    send_w(64'hA5A5_0000_1234_5678, 8'hFF);
    repeat (3) begin
      chk("t2_wready_low_while_held", 64'(s_axil_wready), 64'(0));
      @(posedge ps_clk); #1;
    end
    chk("t2_no_wen_before_aw", 64'(wen_cnt - w0), 64'(0));
    send_aw(32'h08);
    recv_b(0);
    chk("t2_single_wen", 64'(wen_cnt - w0), 64'(1));
    chk("t2_waddr", 64'(last_waddr), 64'(1));
    chk("t2_single_b", 64'(b_cnt - b0), 64'(1));

    // read with R backpressure
    regs[4] = 64'hDEADBEEF00000001;
    model_regs[4] = 64'hDEADBEEF00000001;
    axi_read(32'h20, 5);
    chk("t3_ren_latency", 64'(ren_cyc - ar_hs_cyc), 64'(1));
    chk("t3_rvalid_latency", 64'(r_first_cyc - ar_hs_cyc), 64'(3));
    chk("t3_rdata", last_rdata, 64'hDEADBEEF00000001);
    chk("t3_rresp", 64'(last_rresp), 64'(0));

    // rejected accesses
    w0 = wen_cnt; r0 = ren_cnt;
    axi_write(32'h800, 64'h0123456789ABCDEF, 8'hFF, 0, 1);
    chk("t4_range_bresp", 64'(last_bresp), 64'(2));
    axi_write(32'h10, 64'h0123456789ABCDEF, 8'h0F, -1, 0);
    chk("t4_strb_bresp", 64'(last_bresp), 64'(2));
    axi_read(32'h800, 0);
    chk("t4_no_wen", 64'(wen_cnt - w0), 64'(0));
    chk("t4_no_ren", 64'(ren_cnt - r0), 64'(0));
    chk("t4_rdata_zero", last_rdata, 64'(0));
    chk("t4_rresp", 64'(last_rresp), 64'(2));
`ifdef TLK_AXIL_ERR_CNT_EN
    chk("t4_err_cnt", 64'(o_err_cnt), 64'(3));
`endif

    // concurrent write and read
    fork
      axi_write(32'h28, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF, 0, 2);
      axi_read(32'h30, 1);
    join
    chk("t5_same_cycle_accept", 64'(ar_hs_cyc), 64'(aw_hs_cyc));
    chk("t5_wen_latency", 64'(wen_cyc - aw_hs_cyc), 64'(1));
    chk("t5_ren_latency", 64'(ren_cyc - ar_hs_cyc), 64'(1));
    chk("t5_waddr", 64'(last_waddr), 64'(5));
    chk("t5_raddr", 64'(last_raddr), 64'(6));

    // reset while the read waits for data
    r0 = r_cnt;
    expect_read(32'h20);
    send_ar(32'h20);
    @(posedge ps_clk); #1;
    exp_r_q.delete();
    do_reset(2);
    repeat (6) begin @(posedge ps_clk); #1; end
    chk("t6_dropped_no_r", 64'(r_cnt - r0), 64'(0));
    axi_read(32'h20, 0);
    chk("t6_read_after_reset", last_rdata, 64'hDEADBEEF00000001);
    chk("t6_single_r", 64'(r_cnt - r0), 64'(1));

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      int op = $urandom_range(0, 2);
      wa = rand_addr();
      ra = rand_addr();
      if (model_idx(wa) == model_idx(ra)) ra = ra ^ 32'h8;
      n0 = $urandom_range(0, 9);
      if (op == 0) begin
        axi_write(wa, {$urandom, $urandom}, (n0 == 0) ? 8'($urandom) : 8'hFF,
                  $urandom_range(0, 4) - 2, $urandom_range(0, 3));
      end else if (op == 1) begin
        axi_read(ra, $urandom_range(0, 3));
      end else begin
        fork
          axi_write(wa, {$urandom, $urandom}, (n0 == 0) ? 8'($urandom) : 8'hFF,
                    $urandom_range(0, 4) - 2, $urandom_range(0, 3));
          axi_read(ra, $urandom_range(0, 3));
        join
      end
    end

    repeat (5) begin @(posedge ps_clk); #1; end
    chk("end_w_queue_empty", 64'(exp_w_q.size()), 64'(0));
    chk("end_b_queue_empty", 64'(exp_b_q.size()), 64'(0));
    chk("end_ren_queue_empty", 64'(exp_ren_q.size()), 64'(0));
    chk("end_r_queue_empty", 64'(exp_r_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
